// File: rtl/pixel_mod_pkg.sv
// pixel_mod_pkg: shared widths, frame state encoding and identity modifier for pixel_mod_apply
package pixel_mod_pkg;
    localparam int CH_W_DEF  = 8;
    localparam int MOD_W_DEF = 6;
    localparam int MOD_ID    = 1;
    localparam logic DIV_ID  = 1'b0;
    typedef enum logic {WAIT_SOF, IN_FRAME} frame_state_t;
endpackage

// File: rtl/mod_channel.sv
// mod_channel: one colour channel, saturating multiply or power-of-two shift divide (combinational)
// ports: c channel in, mod modifier, div 1=divide 0=multiply, y channel out
module mod_channel import pixel_mod_pkg::*; #(
    parameter int CH_W  = CH_W_DEF,
    parameter int MOD_W = MOD_W_DEF
) (
    input  logic [CH_W-1:0]  c,
    input  logic [MOD_W-1:0] mod,
    input  logic             div,
    output logic [CH_W-1:0]  y
);
    logic [CH_W+MOD_W-1:0] prod;
    int sh;
    always_comb begin
        prod = {{MOD_W{1'b0}}, c} * {{CH_W{1'b0}}, mod};
        sh = 0;
        for (int i = 0; i < MOD_W; i++) if (mod[i]) sh = i;
        y = div ? ((mod == '0) ? '0 : c >> sh)
                : ((|prod[CH_W+MOD_W-1:CH_W]) ? '1 : prod[CH_W-1:0]);
    end
endmodule

// File: rtl/pixel_mod_apply.sv
// pixel_mod_apply: two-stage stream pipeline applying per-frame channel modifiers to RGB pixels
// ports: clk, reset (sync, active high); r_mod/g_mod/b_mod/div_flag modifier set;
//        s_tdata/s_tvalid/s_tready/s_tuser/s_tlast input stream ({R,G,B}, SOF, EOL);
//        m_tdata/m_tvalid/m_tready/m_tuser/m_tlast output stream; frame_active after first SOF
module pixel_mod_apply import pixel_mod_pkg::*; #(
    parameter int CH_W  = CH_W_DEF,
    parameter int MOD_W = MOD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MOD_W-1:0]  r_mod,
    input  logic [MOD_W-1:0]  g_mod,
    input  logic [MOD_W-1:0]  b_mod,
    input  logic              div_flag,
    input  logic [3*CH_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [3*CH_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              frame_active
);
    frame_state_t state, state_nx;
    logic [MOD_W-1:0] r_sh, g_sh, b_sh;
    logic div_sh;
    logic rdy_en;
    logic s1_full, s1_user, s1_last, s1_div;
    logic [3*CH_W-1:0] s1_data, res;
    logic [3*MOD_W-1:0] s1_mod;
    logic s2_full, s2_ready, s1_adv, s_fire, sof;

    assign s2_ready     = !s2_full || m_tready;
    assign s1_adv       = s1_full && s2_ready;
    // rdy_en keeps s_tready low for the first cycle after reset releases
    assign s_tready     = rdy_en && !reset && (!s1_full || s2_ready);
    assign s_fire       = s_tvalid && s_tready;
    assign sof          = s_fire && s_tuser;
    assign m_tvalid     = s2_full;
    assign frame_active = state == IN_FRAME;

    always_comb begin
        state_nx = state;
        if (sof) state_nx = IN_FRAME;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT_SOF;
            rdy_en  <= 1'b0;
            r_sh    <= MOD_W'(MOD_ID);
            g_sh    <= MOD_W'(MOD_ID);
            b_sh    <= MOD_W'(MOD_ID);
            div_sh  <= DIV_ID;
            s1_full <= 1'b0;
            s1_data <= '0;
            s1_user <= 1'b0;
            s1_last <= 1'b0;
            s1_mod  <= '0;
            s1_div  <= 1'b0;
            s2_full <= 1'b0;
            m_tdata <= '0;
            m_tuser <= 1'b0;
            m_tlast <= 1'b0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
            if (sof) begin
                r_sh   <= r_mod;
                g_sh   <= g_mod;
                b_sh   <= b_mod;
                div_sh <= div_flag;
            end
            // the shadow set stays at identity until the first SOF, so it also covers WAIT_SOF
            if (s_fire) begin
                s1_full <= 1'b1;
                s1_data <= s_tdata;
                s1_user <= s_tuser;
                s1_last <= s_tlast;
                s1_mod  <= sof ? {r_mod, g_mod, b_mod} : {r_sh, g_sh, b_sh};
                s1_div  <= sof ? div_flag : div_sh;
            end else if (s1_adv) begin
                s1_full <= 1'b0;
            end
            if (s1_adv) begin
                s2_full <= 1'b1;
                m_tdata <= res;
                m_tuser <= s1_user;
                m_tlast <= s1_last;
            end else if (m_tready) begin
                s2_full <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        mod_channel #(.CH_W(CH_W), .MOD_W(MOD_W)) u_ch (
            .c   (s1_data[(2-i)*CH_W +: CH_W]),
            .mod (s1_mod[(2-i)*MOD_W +: MOD_W]),
            .div (s1_div),
            .y   (res[(2-i)*CH_W +: CH_W])
        );
    end
endmodule

// File: tb/tb_pixel_mod_apply.sv
// tb_pixel_mod_apply: directed and randomized checks of pixel_mod_apply against a scoreboard model
module tb_pixel_mod_apply;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  r_mod = '0, g_mod = '0, b_mod = '0;
    logic        div_flag = 1'b0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
    logic        s_tready, m_tvalid, m_tuser, m_tlast, frame_active;
    logic [23:0] m_tdata;

    pixel_mod_apply dut (
        .clk(clk), .reset(reset),
        .r_mod(r_mod), .g_mod(g_mod), .b_mod(b_mod), .div_flag(div_flag),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .frame_active(frame_active)
    );

    typedef struct packed {logic [23:0] d; logic u; logic l;} beat_t;
    beat_t q[$];
    int errors = 0, checks = 0, accepted = 0;
    int mr = 1, mg = 1, mb = 1;
    bit md = 1'b0;
    logic stall_prev = 1'b0, last_fire = 1'b0;
    logic [25:0] held = '0;

    function automatic logic [7:0] ch(input int c, input int m, input bit dv);
        int p;
        if (m == 0) return 8'd0;
        if (dv) begin
            p = 1;
            while (p * 2 <= m) p = p * 2;
            return 8'(c / p);
        end
        return 8'((c * m > 255) ? 255 : c * m);
    endfunction

    function automatic logic [23:0] model(input logic [23:0] px);
        return {ch(int'(px[23:16]), mr, md), ch(int'(px[15:8]), mg, md), ch(int'(px[7:0]), mb, md)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [23:0] d, input logic u, input logic l, input logic rdy);
        beat_t b;
        @(negedge clk);
        s_tvalid = v; s_tdata = d; s_tuser = u; s_tlast = l; m_tready = rdy;
        #1;
        if (stall_prev) chk("hold", {5'b0, m_tvalid, m_tdata, m_tuser, m_tlast}, {6'b1, held});
        last_fire = v && s_tready;
        if (last_fire) begin
            accepted++;
            if (u) begin mr = int'(r_mod); mg = int'(g_mod); mb = int'(b_mod); md = div_flag; end
            q.push_back({model(d), u, l});
        end
        if (m_tvalid && rdy) begin
            if (q.size() == 0) chk("extra", 32'(m_tvalid), 32'd0);
            else begin
                b = q.pop_front();
                chk("beat", {6'b0, m_tdata, m_tuser, m_tlast}, {6'b0, b});
            end
        end
        stall_prev = m_tvalid && !rdy;
        held = {m_tdata, m_tuser, m_tlast};
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [23:0] d, input logic u, input logic [23:0] exp, input string tag);
        cycle(1'b1, d, u, 1'b0, 1'b1);
        chk({tag, "_acc"}, 32'(last_fire), 32'd1);
        chk({tag, "_lat1"}, 32'(m_tvalid), 32'd0);
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        chk({tag, "_vld"}, 32'(m_tvalid), 32'd1);
        chk({tag, "_data"}, 32'(m_tdata), 32'(exp));
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_mods(input int r, input int g, input int b, input logic dv);
        r_mod = 6'(r); g_mod = 6'(g); b_mod = 6'(b); div_flag = dv;
    endtask

    initial begin
        repeat (3) cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mdata", 32'(m_tdata), 32'd0);
        chk("rst_markers", 32'({m_tuser, m_tlast}), 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        chk("rst_active", 32'(frame_active), 32'd0);
        reset = 1'b0;
        chk("rel_sready0", 32'(s_tready), 32'd0);
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        chk("rel_sready1", 32'(s_tready), 32'd1);

        set_mods(0, 0, 0, 1'b1);
        one(24'h123456, 1'b0, 24'h123456, "wait_sof");
        chk("wait_active", 32'(frame_active), 32'd0);
        set_mods(1, 1, 1, 1'b0);
        one(24'h804010, 1'b1, 24'h804010, "ident");
        chk("frame_active", 32'(frame_active), 32'd1);
        set_mods(4, 4, 4, 1'b0);
        one(24'h50403F, 1'b1, 24'hFFFFFC, "sat");
        set_mods(4, 2, 3, 1'b1);
        one(24'hF0F0F0, 1'b1, 24'h3C7878, "div");
        set_mods(0, 0, 0, 1'b1);
        one(24'hF0F0F0, 1'b1, 24'h000000, "div0");
        set_mods(0, 0, 0, 1'b0);
        one(24'hABCDEF, 1'b1, 24'h000000, "mul0");
        set_mods(3, 1, 0, 1'b0);
        one(24'h602020, 1'b1, 24'hFF2000, "indep");
        set_mods(1, 1, 1, 1'b0);
        one(24'h112233, 1'b1, 24'h112233, "latch_sof");
        set_mods(0, 0, 0, 1'b0);
        one(24'h445566, 1'b0, 24'h445566, "latch_mid");
        one(24'h778899, 1'b1, 24'h000000, "latch_next");

        accepted = 0;
        for (int n = 0; n < 20000 && accepted < 1000; n++) begin
            set_mods(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), 1'($urandom));
            cycle($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
                  1'($urandom), 1'($urandom));
        end
        chk("rand_beats", 32'(accepted), 32'd1000);
        for (int n = 0; n < 10 && q.size() != 0; n++) cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        chk("drain", 32'(q.size()), 32'd0);

        set_mods(2, 2, 2, 1'b0);
        cycle(1'b1, 24'h010203, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 24'h040506, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 24'h070809, 1'b0, 1'b0, 1'b0);
        chk("full_sready", 32'(s_tready), 32'd0);
        chk("full_mvalid", 32'(m_tvalid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_active", 32'(frame_active), 32'd0);
        reset = 1'b0;
        q.delete();
        mr = 1; mg = 1; mb = 1; md = 1'b0;
        stall_prev = 1'b0;
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_mvalid", 32'(m_tvalid), 32'd0);
        set_mods(0, 0, 0, 1'b1);
        one(24'hC0FFEE, 1'b0, 24'hC0FFEE, "post_rst");
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        chk("final_idle", 32'(m_tvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
